modexp_controller: RTL and testbench

Parametrised control FSM that sequences a modular-multiply datapath through left-to-right square-and-multiply exponentiation over an EXP_WIDTH-bit exponent.
- Supersedes the single modular-multiply controller: one datapath operation = one multiply+modulo pair, reported complete by the datapath.
- Adds exponent-bit scanning, optional leading-zero skipping, a ready/start handshake, abort, and a bit-index status output.
- Sits between the top-level input registers and the shared mod-mult datapath.

---
 rtl/modexp_pkg.sv | 28 ++
 rtl/modexp_controller.sv | 130 +++++++++++++
 tb/tb_modexp_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_pkg.sv
// Shared encodings for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INIT      = 3'd1;
  localparam logic [2:0] ST_SCAN      = 3'd2;
  localparam logic [2:0] ST_SQ_ISSUE  = 3'd3;
  localparam logic [2:0] ST_SQ_WAIT   = 3'd4;
  localparam logic [2:0] ST_MUL_ISSUE = 3'd5;
  localparam logic [2:0] ST_MUL_WAIT  = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_INIT      = ST_INIT,
    S_SCAN      = ST_SCAN,
    S_SQ_ISSUE  = ST_SQ_ISSUE,
    S_SQ_WAIT   = ST_SQ_WAIT,
    S_MUL_ISSUE = ST_MUL_ISSUE,
    S_MUL_WAIT  = ST_MUL_WAIT,
    S_DONE      = ST_DONE
  } state_e;

  // Operand select driven alongside mul_start_o
  localparam logic MUL_SEL_SQUARE = 1'b0;  // acc * acc
  localparam logic MUL_SEL_MULT   = 1'b1;  // acc * base

endpackage

// File: rtl/modexp_controller.sv
// Left-to-right square-and-multiply sequencer for a shared mod-mult datapath.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready for start; exponent captured on accept
// INIT       | one-cycle init pulse: datapath loads acc=1, latches base
// SCAN       | skipping leading zero bits, one bit per cycle
// SQ_ISSUE   | launch acc*acc
// SQ_WAIT    | wait for datapath completion of the square
// MUL_ISSUE  | launch acc*base (current bit is 1)
// MUL_WAIT   | wait for datapath completion of the multiply
// DONE       | one-cycle done pulse, then back to IDLE
module modexp_controller
  import modexp_pkg::*;
#(
  parameter int EXP_WIDTH          = 16,
  parameter bit SKIP_LEADING_ZEROS = 1'b1,
  localparam int CNT_WIDTH         = $clog2(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [EXP_WIDTH-1:0] exponent_i,
  input  logic                 abort_i,
  input  logic                 mul_done_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 init_o,
  output logic                 mul_start_o,
  output logic                 mul_sel_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] bit_index_o
);

  localparam logic [CNT_WIDTH-1:0] IDX_TOP = CNT_WIDTH'(EXP_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] IDX_ONE = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   idx_q, idx_d;
  logic [EXP_WIDTH-1:0]   exp_q, exp_d;
  logic                   ready_q, busy_q, init_q, mul_start_q, mul_sel_q, done_q;
  logic                   cur_bit;
  logic                   last_bit;

  assign cur_bit  = exp_q[idx_q];
  assign last_bit = (idx_q == '0);

  // Next-state, bit index and exponent capture; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            exp_d   = exponent_i;
            idx_d   = IDX_TOP;
            state_d = S_INIT;
          end
        end
        S_INIT: state_d = SKIP_LEADING_ZEROS ? S_SCAN : S_SQ_ISSUE;
        S_SCAN: begin
          if (cur_bit)       state_d = S_SQ_ISSUE;
          else if (last_bit) state_d = S_DONE;
          else               idx_d   = idx_q - IDX_ONE;
        end
        S_SQ_ISSUE: state_d = S_SQ_WAIT;
        S_SQ_WAIT: begin
          if (mul_done_i) begin
            if (cur_bit)       state_d = S_MUL_ISSUE;
            else if (last_bit) state_d = S_DONE;
            else begin
              idx_d   = idx_q - IDX_ONE;
              state_d = S_SQ_ISSUE;
            end
          end
        end
        S_MUL_ISSUE: state_d = S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (mul_done_i) begin
            if (last_bit) state_d = S_DONE;
            else begin
              idx_d   = idx_q - IDX_ONE;
              state_d = S_SQ_ISSUE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; outputs are decoded from the next state so they stay glitch-free registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_TOP;
      exp_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      init_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_sel_q   <= MUL_SEL_SQUARE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_q       <= exp_d;
      ready_q     <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      init_q      <= (state_d == S_INIT);
      mul_start_q <= (state_d == S_SQ_ISSUE) || (state_d == S_MUL_ISSUE);
      mul_sel_q   <= (state_d == S_MUL_ISSUE) ? MUL_SEL_MULT : MUL_SEL_SQUARE;
      done_q      <= (state_d == S_DONE);
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign init_o      = init_q;
  assign mul_start_o = mul_start_q;
  assign mul_sel_o   = mul_sel_q;
  assign done_o      = done_q;
  assign bit_index_o = idx_q;

endmodule

// File: tb/tb_modexp_controller.sv
// Directed bench: instance A is 4-bit without zero skipping, instance B is 16-bit with skipping.
module tb_modexp_controller;

  logic clk, rst_n;

  logic        start_a, abort_a, md_a;
  logic [3:0]  exp_a;
  logic        ready_a, busy_a, init_a, ms_a, sel_a, done_a;
  logic [1:0]  bi_a;

  logic        start_b, abort_b, md_b;
  logic [15:0] exp_b;
  logic        ready_b, busy_b, init_b, ms_b, sel_b, done_b;
  logic [3:0]  bi_b;

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc[2], n_ms[2], n_init[2], n_done[2], done_cyc[2];
  logic [63:0] seq[2], bil[2];

  int dly_a = 1, dly_b = 1;
  bit rand_b = 0, spur_b = 0;
  int cnt_a, cnt_b;

  modexp_controller #(.EXP_WIDTH(4), .SKIP_LEADING_ZEROS(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .exponent_i(exp_a), .abort_i(abort_a),
    .mul_done_i(md_a), .ready_o(ready_a), .busy_o(busy_a), .init_o(init_a),
    .mul_start_o(ms_a), .mul_sel_o(sel_a), .done_o(done_a), .bit_index_o(bi_a));

  modexp_controller #(.EXP_WIDTH(16), .SKIP_LEADING_ZEROS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .exponent_i(exp_b), .abort_i(abort_b),
    .mul_done_i(md_b), .ready_o(ready_b), .busy_o(busy_b), .init_o(init_b),
    .mul_start_o(ms_b), .mul_sel_o(sel_b), .done_o(done_b), .bit_index_o(bi_b));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Datapath model for A: mul_done dly_a cycles after each mul_start
  initial begin
    md_a = 0; cnt_a = 0;
    forever begin
      @(negedge clk);
      md_a = 0;
      if (!rst_n) cnt_a = 0;
      else if (ms_a) cnt_a = dly_a;
      else if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) md_a = 1;
      end
    end
  end

  // Datapath model for B: optional random latency and spurious mul_done in non-wait cycles
  initial begin
    md_b = 0; cnt_b = 0;
    forever begin
      @(negedge clk);
      md_b = 0;
      if (!rst_n) cnt_b = 0;
      else if (ms_b) cnt_b = rand_b ? int'($urandom_range(1, 8)) : dly_b;
      else if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) md_b = 1;
      end
      if (spur_b && (ms_b || init_b || ready_b)) md_b = 1;
    end
  end

  // Observe both instances mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (busy_a) cyc[0]++;
      if (init_a) n_init[0]++;
      if (ms_a) begin
        n_ms[0]++;
        seq[0] = {seq[0][62:0], sel_a};
        bil[0] = {bil[0][59:0], 2'b00, bi_a};
      end
      if (done_a) begin n_done[0]++; done_cyc[0] = cyc[0]; end
      if (busy_b) cyc[1]++;
      if (init_b) n_init[1]++;
      if (ms_b) begin
        n_ms[1]++;
        seq[1] = {seq[1][62:0], sel_b};
        bil[1] = {bil[1][59:0], bi_b};
      end
      if (done_b) begin n_done[1]++; done_cyc[1] = cyc[1]; end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(input int d);
    cyc[d] = 0; n_ms[d] = 0; n_init[d] = 0; n_done[d] = 0; done_cyc[d] = 0;
    seq[d] = '0; bil[d] = '0;
  endtask

  task automatic start_run(input int d, input logic [15:0] e);
    clear_mon(d);
    if (d == 0) begin start_a = 1; exp_a = e[3:0]; end
    else        begin start_b = 1; exp_b = e; end
    tick();
    start_a = 0; start_b = 0;
  endtask

  task automatic wait_done(input int d, input int limit, input string name);
    int k = 0;
    while (n_done[d] == 0 && k < limit) begin tick(); k++; end
    if (n_done[d] == 0) begin
      n_checks++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_issue(input int d, input logic sel, input int bi, input int limit, input string name);
    int  k = 0;
    bit  hit = 0;
    while (!hit && k < limit) begin
      tick(); k++;
      if (d == 0) hit = ms_a && (sel_a == sel) && (int'(bi_a) == bi);
      else        hit = ms_b && (sel_b == sel) && (int'(bi_b) == bi);
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL %s_timeout: issue sel=%0d bit=%0d not seen", name, sel, bi);
    end
  endtask

  task automatic test_reset();
    rst_n = 1;
    #1 rst_n = 0;
    #6;
    n_checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) $display("FAIL rst_ready: got %b%b want 11", ready_a, ready_b); else n_pass++;
    n_checks++; if ({busy_a, init_a, ms_a, sel_a, done_a} !== 5'b0) $display("FAIL rst_outs_a: got %b want 00000", {busy_a, init_a, ms_a, sel_a, done_a}); else n_pass++;
    n_checks++; if ({busy_b, init_b, ms_b, sel_b, done_b} !== 5'b0) $display("FAIL rst_outs_b: got %b want 00000", {busy_b, init_b, ms_b, sel_b, done_b}); else n_pass++;
    n_checks++; if (bi_a !== 2'd3 || bi_b !== 4'd15) $display("FAIL rst_idx: got %0d/%0d want 3/15", bi_a, bi_b); else n_pass++;
    tick();
    rst_n = 1;
    tick(); tick();
  endtask

  task automatic test_full_scan_a();
    start_run(0, 16'h000B);
    exp_a = 4'b0000;
    wait_done(0, 60, "a1011");
    n_checks++; if (n_ms[0] !== 7) $display("FAIL a1011_ops: got %0d want 7", n_ms[0]); else n_pass++;
    n_checks++; if (seq[0][6:0] !== 7'b0100101) $display("FAIL a1011_sel: got %b want 0100101", seq[0][6:0]); else n_pass++;
    n_checks++; if (bil[0][27:0] !== 28'h3321100) $display("FAIL a1011_idx: got %h want 3321100", bil[0][27:0]); else n_pass++;
    n_checks++; if (done_cyc[0] !== 16) $display("FAIL a1011_lat: got %0d want 16", done_cyc[0]); else n_pass++;
    n_checks++; if (n_init[0] !== 1) $display("FAIL a1011_init: got %0d want 1", n_init[0]); else n_pass++;
    tick();
    n_checks++; if (ready_a !== 1'b1 || n_done[0] !== 1) $display("FAIL a1011_end: ready %b done %0d want 1/1", ready_a, n_done[0]); else n_pass++;
  endtask

  task automatic test_skip_b();
    start_run(1, 16'h000B);
    wait_done(1, 80, "b000b");
    n_checks++; if (n_ms[1] !== 7) $display("FAIL b000b_ops: got %0d want 7", n_ms[1]); else n_pass++;
    n_checks++; if (seq[1][6:0] !== 7'b0100101) $display("FAIL b000b_sel: got %b want 0100101", seq[1][6:0]); else n_pass++;
    n_checks++; if (bil[1][27:0] !== 28'h3321100) $display("FAIL b000b_idx: got %h want 3321100", bil[1][27:0]); else n_pass++;
    n_checks++; if (done_cyc[1] !== 29) $display("FAIL b000b_lat: got %0d want 29", done_cyc[1]); else n_pass++;
    tick();
    n_checks++; if (ready_b !== 1'b1 || n_done[1] !== 1) $display("FAIL b000b_end: ready %b done %0d want 1/1", ready_b, n_done[1]); else n_pass++;
  endtask

  task automatic test_zero_exp();
    start_run(1, 16'h0000);
    wait_done(1, 60, "bzero");
    n_checks++; if (n_ms[1] !== 0 || n_init[1] !== 1) $display("FAIL bzero_ops: ops %0d init %0d want 0/1", n_ms[1], n_init[1]); else n_pass++;
    n_checks++; if (done_cyc[1] !== 18) $display("FAIL bzero_lat: got %0d want 18", done_cyc[1]); else n_pass++;
    tick();
    start_run(0, 16'h0000);
    wait_done(0, 60, "azero");
    n_checks++; if (n_ms[0] !== 4 || seq[0][3:0] !== 4'b0000) $display("FAIL azero_ops: ops %0d sel %b want 4/0000", n_ms[0], seq[0][3:0]); else n_pass++;
    n_checks++; if (bil[0][15:0] !== 16'h3210) $display("FAIL azero_idx: got %h want 3210", bil[0][15:0]); else n_pass++;
    n_checks++; if (done_cyc[0] !== 10) $display("FAIL azero_lat: got %0d want 10", done_cyc[0]); else n_pass++;
    tick();
  endtask

  task automatic test_random_delays();
    rand_b = 1; spur_b = 1;
    tick(); tick();
    start_run(1, 16'hA5C3);
    wait_done(1, 600, "brand");
    n_checks++; if (n_ms[1] !== 24) $display("FAIL brand_ops: got %0d want 24", n_ms[1]); else n_pass++;
    n_checks++; if (seq[1][23:0] !== 24'h489505) $display("FAIL brand_sel: got %h want 489505", seq[1][23:0]); else n_pass++;
    repeat (5) tick();
    n_checks++; if (n_done[1] !== 1 || n_ms[1] !== 24 || ready_b !== 1'b1) $display("FAIL brand_idle: done %0d ops %0d ready %b want 1/24/1", n_done[1], n_ms[1], ready_b); else n_pass++;
    rand_b = 0; spur_b = 0;
    tick();
  endtask

  task automatic test_abort();
    start_run(0, 16'h0006);
    wait_issue(0, 1'b0, 2, 40, "abort");
    tick();
    abort_a = 1;
    tick();
    abort_a = 0;
    n_checks++; if (ready_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL abort_idle: ready %b busy %b want 1/0", ready_a, busy_a); else n_pass++;
    repeat (6) tick();
    n_checks++; if (n_ms[0] !== 2 || n_done[0] !== 0) $display("FAIL abort_quiet: ops %0d done %0d want 2/0", n_ms[0], n_done[0]); else n_pass++;
    clear_mon(0);
    start_a = 1; abort_a = 1; exp_a = 4'b0001;
    tick();
    start_a = 0; abort_a = 0;
    n_checks++; if (init_a !== 1'b1) $display("FAIL abort_restart: init %b want 1", init_a); else n_pass++;
    wait_done(0, 60, "restart");
    n_checks++; if (n_ms[0] !== 5 || seq[0][4:0] !== 5'b00001) $display("FAIL restart_ops: ops %0d sel %b want 5/00001", n_ms[0], seq[0][4:0]); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    dly_b = 8;
    start_run(1, 16'h8001);
    wait_issue(1, 1'b1, 0, 400, "rstmid");
    tick();
    n_checks++; if (busy_b !== 1'b1 || bi_b !== 4'd0) $display("FAIL rstmid_pre: busy %b idx %0d want 1/0", busy_b, bi_b); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++; if (ready_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL rstmid_async: ready %b busy %b want 1/0", ready_b, busy_b); else n_pass++;
    n_checks++; if ({init_b, ms_b, sel_b, done_b} !== 4'b0 || bi_b !== 4'd15) $display("FAIL rstmid_outs: outs %b idx %0d want 0000/15", {init_b, ms_b, sel_b, done_b}, bi_b); else n_pass++;
    tick();
    rst_n = 1;
    dly_b = 1;
    tick();
    n_checks++; if (n_done[1] !== 0 || ready_b !== 1'b1) $display("FAIL rstmid_after: done %0d ready %b want 0/1", n_done[1], ready_b); else n_pass++;
  endtask

  task automatic test_start_held();
    clear_mon(0);
    start_a = 1; exp_a = 4'b0001;
    tick();
    wait_done(0, 60, "held");
    n_checks++; if (n_init[0] !== 1) $display("FAIL held_init: got %0d want 1", n_init[0]); else n_pass++;
    tick();
    n_checks++; if (ready_a !== 1'b1) $display("FAIL held_idle: ready %b want 1", ready_a); else n_pass++;
    tick();
    n_checks++; if (init_a !== 1'b1) $display("FAIL held_accept: init %b want 1", init_a); else n_pass++;
    start_a = 0; abort_a = 1;
    tick();
    abort_a = 0;
    n_checks++; if (ready_a !== 1'b1 || n_done[0] !== 1) $display("FAIL held_abort: ready %b done %0d want 1/1", ready_a, n_done[0]); else n_pass++;
  endtask

  initial begin
    start_a = 0; abort_a = 0; exp_a = '0;
    start_b = 0; abort_b = 0; exp_b = '0;
    clear_mon(0); clear_mon(1);
    test_reset();
    test_full_scan_a();
    test_skip_b();
    test_zero_exp();
    test_random_delays();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
